// File: rtl/rgb332_tmds_encoder_pkg.sv
// ============================================================================
// Module : rgb332_tmds_encoder_pkg
// Brief  : Shared TMDS constants, stage-1 record and small helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rgb332_tmds_encoder_pkg;

    localparam int TMDS_DISP_W = 5;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    localparam logic [1:0] CTL_NONE = 2'b00;

    typedef struct packed {
        logic [8:0] qm;
        logic [3:0] n1;
        logic       blank;
        logic [1:0] ctl;
    } stage1_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] ctl);
        logic [9:0] s;
        case (ctl)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb332_tmds_encoder_channel.sv
// ============================================================================
// Module : tmds_channel_encoder
// Brief  : One DVI TMDS lane: transition minimisation, then DC balancing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tmds_channel_encoder
    import rgb332_tmds_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] d_i,
    input  logic       blank_i,
    input  logic [1:0] ctl_i,
    output logic [9:0] tmds_o
);

    localparam int SUM_W = TMDS_DISP_W + 2;

    stage1_t                       s1_d, s1_q;
    logic                          use_xnor;
    logic [3:0]                    n1_din;
    logic signed [TMDS_DISP_W-1:0] cnt_d, cnt_q;
    logic [9:0]                    tmds_d, tmds_q;

    logic                    qm8;
    logic                    cnt_pos, cnt_neg;
    logic signed [SUM_W-1:0] diff, cnt_ext, cnt_sum;

    always_comb begin
        logic [8:0] qm;
        qm       = '0;
        n1_din   = popcount8(d_i);
        use_xnor = (n1_din > 4'd4) || ((n1_din == 4'd4) && !d_i[0]);
        qm[0]    = d_i[0];
        // XNOR is XOR followed by inversion, so fold the mode in as an extra XOR term.
        for (int i = 1; i < 8; i++) begin
            qm[i] = qm[i-1] ^ d_i[i] ^ use_xnor;
        end
        qm[8]       = ~use_xnor;
        s1_d        = '0;
        s1_d.qm     = qm;
        s1_d.n1     = popcount8(qm[7:0]);
        s1_d.blank  = blank_i;
        s1_d.ctl    = ctl_i;
    end

    always_comb begin
        qm8     = s1_q.qm[8];
        cnt_pos = !cnt_q[TMDS_DISP_W-1] && (cnt_q != '0);
        cnt_neg = cnt_q[TMDS_DISP_W-1];
        // N1 - N0 == 2*N1 - 8 for an 8-bit word.
        diff    = $signed({2'b00, s1_q.n1, 1'b0}) - $signed(SUM_W'(8));
        cnt_ext = {{(SUM_W-TMDS_DISP_W){cnt_q[TMDS_DISP_W-1]}}, cnt_q};
        cnt_sum = '0;
        tmds_d  = CTRL_00;
        if (s1_q.blank) begin
            tmds_d  = ctrl_symbol(s1_q.ctl);
            cnt_sum = '0;
        end else if ((cnt_q == '0) || (s1_q.n1 == 4'd4)) begin
            tmds_d  = {~qm8, qm8, qm8 ? s1_q.qm[7:0] : ~s1_q.qm[7:0]};
            cnt_sum = cnt_ext + (qm8 ? diff : -diff);
        end else if ((cnt_pos && (s1_q.n1 > 4'd4)) || (cnt_neg && (s1_q.n1 < 4'd4))) begin
            tmds_d  = {1'b1, qm8, ~s1_q.qm[7:0]};
            cnt_sum = cnt_ext + (qm8 ? $signed(SUM_W'(2)) : $signed(SUM_W'(0))) - diff;
        end else begin
            tmds_d  = {1'b0, qm8, s1_q.qm[7:0]};
            cnt_sum = cnt_ext + diff - (qm8 ? $signed(SUM_W'(0)) : $signed(SUM_W'(2)));
        end
        cnt_d = cnt_sum[TMDS_DISP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q.qm    <= '0;
            s1_q.n1    <= '0;
            s1_q.blank <= 1'b1;
            s1_q.ctl   <= CTL_NONE;
            cnt_q      <= '0;
            tmds_q     <= CTRL_00;
        end else begin
            s1_q   <= s1_d;
            cnt_q  <= cnt_d;
            tmds_q <= tmds_d;
        end
    end

    assign tmds_o = tmds_q;

endmodule

`default_nettype wire

// File: rtl/rgb332_tmds_encoder.sv
// ============================================================================
// Module : rgb332_tmds_encoder
// Brief  : RGB332 to 8:8:8 expansion feeding three TMDS lane encoders.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rgb332_tmds_encoder
    import rgb332_tmds_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       blank,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] r,
    input  logic [2:0] g,
    input  logic [1:0] b,
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b
);

    logic [7:0] w_r8, w_g8, w_b8;

    // Bit replication maps 0 to 0x00 and full scale to 0xFF.
    assign w_r8 = {r, r, r[2:1]};
    assign w_g8 = {g, g, g[2:1]};
    assign w_b8 = {b, b, b, b};

    tmds_channel_encoder u_red (
        .clk     (clk),
        .reset   (reset),
        .d_i     (w_r8),
        .blank_i (blank),
        .ctl_i   (CTL_NONE),
        .tmds_o  (tmds_r)
    );

    tmds_channel_encoder u_green (
        .clk     (clk),
        .reset   (reset),
        .d_i     (w_g8),
        .blank_i (blank),
        .ctl_i   (CTL_NONE),
        .tmds_o  (tmds_g)
    );

    tmds_channel_encoder u_blue (
        .clk     (clk),
        .reset   (reset),
        .d_i     (w_b8),
        .blank_i (blank),
        .ctl_i   ({vsync, hsync}),
        .tmds_o  (tmds_b)
    );

endmodule

`default_nettype wire

// File: tb/tb_rgb332_tmds_encoder.sv
// ============================================================================
// Module : tb_rgb332_tmds_encoder
// Brief  : Directed vectors, randomized stream against a DVI reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rgb332_tmds_encoder;

    logic       clk = 1'b0;
    logic       reset, blank, hsync, vsync;
    logic [2:0] r, g;
    logic [1:0] b;
    logic [9:0] tmds_r, tmds_g, tmds_b;

    int checks = 0;
    int errors = 0;

    rgb332_tmds_encoder dut (
        .clk    (clk),
        .reset  (reset),
        .blank  (blank),
        .hsync  (hsync),
        .vsync  (vsync),
        .r      (r),
        .g      (g),
        .b      (b),
        .tmds_r (tmds_r),
        .tmds_g (tmds_g),
        .tmds_b (tmds_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       blank;
        logic [1:0] ctl;
        logic [7:0] dr, dg, db;
    } pix_t;

    typedef struct packed {
        logic       rst;
        logic       bl;
        logic [1:0] ctl;
        logic [2:0] r, g;
        logic [1:0] b;
        logic [9:0] er, eg, eb;
    } vec_t;

    logic [9:0] ctrl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    pix_t       s1, prev;
    int         mcnt [3];
    logic [9:0] mexp [3];
    int         dcnt [3];

    // Evenly spaced 0..255 scale, rounded to nearest.
    function automatic logic [7:0] scale(input int v, input int maxv);
        int x;
        x = (v * 510 + maxv) / (2 * maxv);
        return x[7:0];
    endfunction

    function automatic logic [9:0] enc(input int ch, input logic [7:0] d,
                                       input logic bl, input logic [1:0] ctl);
        int         n1, q1, q0;
        logic       xn;
        logic [8:0] qm;
        logic [9:0] o;
        if (bl) begin
            mcnt[ch] = 0;
            return ctrl_tab[ctl];
        end
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && !d[0]);
        // Bit i of q_m is the parity of d[i:0], inverted on odd i in XNOR mode.
        for (int i = 0; i < 8; i++) begin
            qm[i] = (($countones(d & 8'((1 << (i + 1)) - 1)) % 2) == 1) ^ (xn && (i % 2 == 1));
        end
        qm[8] = !xn;
        q1 = $countones(qm[7:0]);
        q0 = 8 - q1;
        if (mcnt[ch] == 0 || q1 == q0) begin
            o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt[ch] += qm[8] ? (q1 - q0) : (q0 - q1);
        end else if ((mcnt[ch] > 0 && q1 > q0) || (mcnt[ch] < 0 && q0 > q1)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            mcnt[ch] += (qm[8] ? 2 : 0) + q0 - q1;
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            mcnt[ch] += q1 - q0 - (qm[8] ? 0 : 2);
        end
        return o;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] w);
        logic [7:0] d, o;
        d    = w[9] ? ~w[7:0] : w[7:0];
        o    = '0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic bl, input logic [1:0] ctl,
                        input logic [2:0] rr, input logic [2:0] gg, input logic [1:0] bb);
        reset = rst;
        blank = bl;
        vsync = ctl[1];
        hsync = ctl[0];
        r     = rr;
        g     = gg;
        b     = bb;
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                mexp[c] = 10'h354;
                mcnt[c] = 0;
            end
            s1   = '{blank: 1'b1, ctl: 2'b00, dr: 8'h00, dg: 8'h00, db: 8'h00};
            prev = s1;
        end else begin
            prev    = s1;
            mexp[0] = enc(0, s1.dr, s1.blank, 2'b00);
            mexp[1] = enc(1, s1.dg, s1.blank, 2'b00);
            mexp[2] = enc(2, s1.db, s1.blank, s1.ctl);
            s1 = '{blank: bl, ctl: ctl, dr: scale(int'(rr), 7),
                   dg: scale(int'(gg), 7), db: scale(int'(bb), 3)};
        end
        #1;
    endtask

    task automatic stream_checks();
        logic [9:0] act [3];
        logic [7:0] pd  [3];
        act[0] = tmds_r; act[1] = tmds_g; act[2] = tmds_b;
        pd[0]  = prev.dr; pd[1] = prev.dg; pd[2] = prev.db;
        check("rand_r", act[0], mexp[0]);
        check("rand_g", act[1], mexp[1]);
        check("rand_b", act[2], mexp[2]);
        for (int c = 0; c < 3; c++) begin
            if (prev.blank) begin
                dcnt[c] = 0;
            end else begin
                check("decode", {2'b00, dec(act[c])}, {2'b00, pd[c]});
                dcnt[c] += 2 * $countones(act[c]) - 10;
                checks++;
                if (dcnt[c] > 8 || dcnt[c] < -8) begin
                    errors++;
                    $display("FAIL disparity_bound ch%0d: got %0d expected -8..8", c, dcnt[c]);
                end
            end
        end
    endtask

    vec_t tv [$];

    initial begin
        reset = 1'b1; blank = 1'b1; hsync = 1'b0; vsync = 1'b0;
        r = '0; g = '0; b = '0;

        //          rst  bl   ctl    r     g     b     er       eg       eb
        tv.push_back('{1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});
        tv.push_back('{1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});
        tv.push_back('{1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});
        tv.push_back('{1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});
        tv.push_back('{1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});
        tv.push_back('{1'b0, 1'b1, 2'b01, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});
        tv.push_back('{1'b0, 1'b1, 2'b10, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h0AB});
        tv.push_back('{1'b0, 1'b1, 2'b11, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h154});
        tv.push_back('{1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h2AB});
        tv.push_back('{1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});
        tv.push_back('{1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 10'h100, 10'h100, 10'h100});
        tv.push_back('{1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 10'h3FF, 10'h3FF, 10'h3FF});
        tv.push_back('{1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h100, 10'h100, 10'h100});
        tv.push_back('{1'b0, 1'b0, 2'b00, 3'd7, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});
        tv.push_back('{1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h200, 10'h100, 10'h100});
        tv.push_back('{1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 10'h354, 10'h354, 10'h354});

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].bl, tv[i].ctl, tv[i].r, tv[i].g, tv[i].b);
            check($sformatf("vec%0d_r", i), tmds_r, tv[i].er);
            check($sformatf("vec%0d_g", i), tmds_g, tv[i].eg);
            check($sformatf("vec%0d_b", i), tmds_b, tv[i].eb);
        end

        step(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0);
        step(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0);
        for (int c = 0; c < 3; c++) dcnt[c] = 0;

        for (int i = 0; i < 10000; i++) begin
            logic bl;
            bl = (i % 100 >= 80) || (i >= 9000 && $urandom_range(1, 0) == 1);
            step(1'b0, bl, 2'($urandom_range(3, 0)), 3'($urandom), 3'($urandom), 2'($urandom));
            stream_checks();
        end

        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'b00, 3'($urandom), 3'($urandom), 2'($urandom));
        end
        step(1'b1, 1'b0, 2'b00, 3'd5, 3'd2, 2'd1);
        check("midrst_r", tmds_r, 10'h354);
        check("midrst_g", tmds_g, 10'h354);
        check("midrst_b", tmds_b, 10'h354);
        step(1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0);
        check("postrst_r", tmds_r, 10'h354);
        check("postrst_b", tmds_b, 10'h354);
        step(1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0);
        check("postrst_first_r", tmds_r, 10'h100);
        check("postrst_first_g", tmds_g, 10'h100);
        check("postrst_first_b", tmds_b, 10'h100);
        step(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0);
        check("postrst_second_r", tmds_r, 10'h3FF);
        check("postrst_second_b", tmds_b, 10'h3FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
